// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-beat AXI3 slave in front of a word-addressed SRAM.
// Define AXI_SLV_RANGE_CHK_EN to answer DECERR for addresses beyond the array.

`ifndef AXI_SRAM_L_WIDTHS
`define AXI_SRAM_L_WIDTHS
`define Larid    4
`define Laraddr  32
`define Larlen   4
`define Larsize  3
`define Larburst 2
`define Larlock  2
`define Larcache 4
`define Larprot  3
`define Lrid     4
`define Lrdata   32
`define Lrresp   2
`define Lawid    4
`define Lawaddr  32
`define Lawlen   4
`define Lawsize  3
`define Lawburst 2
`define Lawlock  2
`define Lawcache 4
`define Lawprot  3
`define Lwid     4
`define Lwdata   32
`define Lwstrb   4
`define Lbid     4
`define Lbresp   2
`endif

module axi_sram_slave #(
  parameter int ADDR_W = 10
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [`Larid-1:0]     arid,
  input  logic [`Laraddr-1:0]   araddr,
  input  logic [`Larlen-1:0]    arlen,
  input  logic [`Larsize-1:0]   arsize,
  input  logic [`Larburst-1:0]  arburst,
  input  logic [`Larlock-1:0]   arlock,
  input  logic [`Larcache-1:0]  arcache,
  input  logic [`Larprot-1:0]   arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [`Lrid-1:0]      rid,
  output logic [`Lrdata-1:0]    rdata,
  output logic [`Lrresp-1:0]    rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [`Lawid-1:0]     awid,
  input  logic [`Lawaddr-1:0]   awaddr,
  input  logic [`Lawlen-1:0]    awlen,
  input  logic [`Lawsize-1:0]   awsize,
  input  logic [`Lawburst-1:0]  awburst,
  input  logic [`Lawlock-1:0]   awlock,
  input  logic [`Lawcache-1:0]  awcache,
  input  logic [`Lawprot-1:0]   awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [`Lwid-1:0]      wid,
  input  logic [`Lwdata-1:0]    wdata,
  input  logic [`Lwstrb-1:0]    wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [`Lbid-1:0]      bid,
  output logic [`Lbresp-1:0]    bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  dbg_r_state
);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where valid & ready are both 1; valid never waits on ready, and no ready
  // here is a combinational function of any incoming valid.

  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  r_state_t    r_state, r_state_nxt;
  logic [31:0] mem [2**ADDR_W];

  logic ar_hs, ar_oor;
  logic aw_hs, w_hs, wr_fire, wr_oor;
  logic aw_got, w_got;
  logic [`Lawaddr-1:0] awaddr_q, wr_addr;
  logic [`Lawid-1:0]   awid_q, wr_id;
  logic [`Lwdata-1:0]  wdata_q, wr_data;
  logic [`Lwstrb-1:0]  wstrb_q, wr_strb;
  logic [ADDR_W-1:0]   wr_idx;

  assign rvalid      = (r_state == R_RESP);
  assign dbg_r_state = (r_state == R_RESP);
  assign rlast       = 1'b1;
  assign arready     = ~rvalid | rready;
  assign ar_hs       = arvalid & arready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_RESP;
      R_RESP:  if (rready) r_state_nxt = ar_hs ? R_RESP : R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Array read happens at the AR edge, so a same-edge write is not yet visible.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rid   <= '0;
      rdata <= '0;
      rresp <= '0;
    end else if (ar_hs) begin
      rid   <= arid;
      rdata <= ar_oor ? '0 : mem[araddr[ADDR_W+1:2]];
      rresp <= ar_oor ? 2'b11 : 2'b00;
    end
  end

  assign awready = ~aw_got & ~bvalid;
  assign wready  = ~w_got & ~bvalid;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign wr_fire = (aw_got | aw_hs) & (w_got | w_hs);
  assign wr_addr = aw_got ? awaddr_q : awaddr;
  assign wr_id   = aw_got ? awid_q : awid;
  assign wr_data = w_got ? wdata_q : wdata;
  assign wr_strb = w_got ? wstrb_q : wstrb;
  assign wr_idx  = wr_addr[ADDR_W+1:2];

`ifdef AXI_SLV_RANGE_CHK_EN
  assign ar_oor = |araddr[`Laraddr-1:ADDR_W+2];
  assign wr_oor = |wr_addr[`Lawaddr-1:ADDR_W+2];
`else
  assign ar_oor = 1'b0;
  assign wr_oor = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= '0;
      awid_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= '0;
    end else if (wr_fire) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      bvalid <= 1'b1;
      bid    <= wr_id;
      bresp  <= wr_oor ? 2'b11 : 2'b00;
    end else begin
      if (aw_hs) begin
        aw_got   <= 1'b1;
        awaddr_q <= awaddr;
        awid_q   <= awid;
      end
      if (w_hs) begin
        w_got   <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (bvalid && bready) bvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_fire && !wr_oor) begin
      for (int i = 0; i < `Lwstrb; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Burst attributes and the address bits outside the word index are unused.
  logic unused_ok;
  assign unused_ok = ^{arlen, arsize, arburst, arlock, arcache, arprot,
                       awlen, awsize, awburst, awlock, awcache, awprot,
                       wid, wlast, araddr, wr_addr};

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: random + directed traffic against a transaction-level
// memory model; expected R/B responses flow through queues to a monitor.

`ifndef AXI_SRAM_L_WIDTHS
`define AXI_SRAM_L_WIDTHS
`define Larid    4
`define Laraddr  32
`define Larlen   4
`define Larsize  3
`define Larburst 2
`define Larlock  2
`define Larcache 4
`define Larprot  3
`define Lrid     4
`define Lrdata   32
`define Lrresp   2
`define Lawid    4
`define Lawaddr  32
`define Lawlen   4
`define Lawsize  3
`define Lawburst 2
`define Lawlock  2
`define Lawcache 4
`define Lawprot  3
`define Lwid     4
`define Lwdata   32
`define Lwstrb   4
`define Lbid     4
`define Lbresp   2
`endif

module tb_axi_sram_slave;
  localparam int ADDR_W = 10;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [3:0]  arlen, arcache, awlen, awcache, wstrb;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic dbg_r_state;

  axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_r_state(dbg_r_state)
  );

  int chk_total = 0;
  int chk_pass  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_total++;
    if (got === exp) chk_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  logic [37:0] exp_r_q[$];   // {rid, rresp, rdata}
  logic [5:0]  exp_b_q[$];   // {bid, bresp}
  logic [35:0] pend_aw_q[$]; // {awid, awaddr}
  logic [35:0] pend_w_q[$];  // {wstrb, wdata}

  function automatic bit oor(input logic [31:0] a);
`ifdef AXI_SLV_RANGE_CHK_EN
    return a[31:ADDR_W+2] != '0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [ADDR_W-1:0] w;
    w = a[ADDR_W+1:2];
    return int'(w);
  endfunction

  function automatic logic [31:0] mem_rd(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
  endfunction

  // Observes the handshakes about to complete on the next rising edge.
  bit exp_rv_next = 0, exp_bv_next = 0;
  logic [35:0] obs_aw, obs_w;
  logic [31:0] obs_v;
  int obs_i;

  always @(negedge aclk) begin
    if (!aresetn) begin
      exp_rv_next = 0;
      exp_bv_next = 0;
      pend_aw_q.delete();
      pend_w_q.delete();
    end else begin
      if (exp_rv_next) check("rvalid_latency", rvalid, 1);
      if (exp_bv_next) check("bvalid_latency", bvalid, 1);
      check("arready_rule", arready, !rvalid || rready);
      if (bvalid) check("aw_w_blocked", {awready, wready}, 0);
      // read sees memory before any write completing on the same edge
      exp_rv_next = arvalid && arready;
      if (exp_rv_next) begin
        if (oor(araddr)) exp_r_q.push_back({arid, 2'b11, 32'h0});
        else             exp_r_q.push_back({arid, 2'b00, mem_rd(widx(araddr))});
      end
      if (awvalid && awready) pend_aw_q.push_back({awid, awaddr});
      if (wvalid && wready)   pend_w_q.push_back({wstrb, wdata});
      exp_bv_next = 0;
      if (pend_aw_q.size() > 0 && pend_w_q.size() > 0) begin
        obs_aw = pend_aw_q.pop_front();
        obs_w  = pend_w_q.pop_front();
        if (oor(obs_aw[31:0])) begin
          exp_b_q.push_back({obs_aw[35:32], 2'b11});
        end else begin
          obs_i = widx(obs_aw[31:0]);
          obs_v = mem_rd(obs_i);
          for (int b = 0; b < 4; b++)
            if (obs_w[32+b]) obs_v[8*b +: 8] = obs_w[8*b +: 8];
          ref_mem[obs_i] = obs_v;
          exp_b_q.push_back({obs_aw[35:32], 2'b00});
        end
        exp_bv_next = 1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge aclk) begin
    if (aresetn) begin
      if (rvalid) begin
        if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          check("rdata", rdata, exp_r_q[0][31:0]);
          check("rresp", rresp, exp_r_q[0][33:32]);
          check("rid", rid, exp_r_q[0][37:34]);
          check("rlast", rlast, 1);
          if (rready) void'(exp_r_q.pop_front());
        end
      end
      if (bvalid) begin
        if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
        else begin
          check("bresp", bresp, exp_b_q[0][1:0]);
          check("bid", bid, exp_b_q[0][5:2]);
          if (bready) void'(exp_b_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  bit rand_ready = 0;
  always @(posedge aclk) begin
    #1;
    if (rand_ready) begin
      rready = ($urandom_range(0, 3) != 0);
      bready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic do_ar(input logic [31:0] a, input logic [3:0] id);
    int n = 0;
    araddr = a; arid = id; arprot = 3'($urandom_range(0, 7)); arvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!arready && n < 200);
    if (!arready) check("ar_timeout", 0, 1);
    @(posedge aclk); #1 arvalid = 1'b0;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [3:0] id);
    int n = 0;
    awaddr = a; awid = id; awprot = 3'($urandom_range(0, 7)); awvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!awready && n < 200);
    if (!awready) check("aw_timeout", 0, 1);
    @(posedge aclk); #1 awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!wready && n < 200);
    if (!wready) check("w_timeout", 0, 1);
    @(posedge aclk); #1 wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id,
                          input logic [31:0] d, input logic [3:0] s);
    fork
      do_aw(a, id);
      do_w(d, s);
    join
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_bvalid"}, bvalid, 0);
    check({tag, "_readies"}, {arready, awready, wready}, 3'b111);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_ids_resps"}, {rid, bid, rresp, bresp}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [31:0] a;
  initial begin
    {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid} = '0;
    {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
    {wid, wdata, wstrb, wvalid} = '0;
    wlast = 1'b1; rready = 1'b1; bready = 1'b1;
    idle(3);
    check_reset_values("reset");
    aresetn = 1'b1;
    idle(2);

    // preload the words used by all tests
    for (int i = 0; i < 16; i++) do_write(32'(i * 4), 4'(i), $urandom, 4'hF);

    // write then read
    do_write(32'h10, 4'h3, 32'hDEADBEEF, 4'hF);
    do_ar(32'h10, 4'h9);

    // byte strobes, then an all-zero strobe
    do_write(32'h30, 4'h1, 32'h11223344, 4'hF);
    do_write(32'h30, 4'h2, 32'hAABBCCDD, 4'b0101);
    do_ar(32'h30, 4'h4);
    do_write(32'h30, 4'h5, 32'hFFFFFFFF, 4'h0);
    do_ar(32'h30, 4'h6);

    // W three cycles before AW, then AW three cycles before W, bready low
    for (int k = 0; k < 2; k++) begin
      bready = 1'b0;
      fork
        begin if (k == 0) idle(3); do_aw(32'h14, 4'h7); end
        begin if (k == 1) idle(3); do_w(32'h5A5A0000 + 32'(k), 4'hF); end
      join
      idle(4);
      check("b_held", bvalid, 1);
      bready = 1'b1;
      idle(1);
      do_ar(32'h14, 4'h8);
    end

    // back-to-back reads, then a stalled read
    do_ar(32'h0, 4'h1);
    do_ar(32'h4, 4'h2);
    do_ar(32'h8, 4'h3);
    rready = 1'b0;
    fork
      begin do_ar(32'hC, 4'h4); do_ar(32'h10, 4'h5); end
      begin idle(3); check("stall_arready", arready, 0); rready = 1'b1; end
    join

    // same-edge read/write collision
    do_write(32'h20, 4'h1, 32'h1, 4'hF);
    idle(1);
    fork
      do_aw(32'h20, 4'h2);
      do_w(32'h2, 4'hF);
      do_ar(32'h20, 4'h3);
    join
    do_ar(32'h20, 4'h4);

    // out-of-range (or aliased) accesses
    do_ar(32'h0010_0000, 4'hA);
    do_write(32'h0010_0010, 4'hB, 32'hBAD0BAD0, 4'hF);
    do_ar(32'h10, 4'hC);

    // randomized traffic
    rand_ready = 1;
    for (int it = 0; it < 150; it++) begin
      a = {($urandom_range(0, 3) == 0) ? 20'($urandom_range(1, 20'hFFFFF)) : 20'h0,
           6'h0, 4'($urandom_range(0, 15)), 2'b00};
      case ($urandom_range(0, 2))
        0: do_ar(a, 4'($urandom));
        1: do_write(a, 4'($urandom), $urandom, 4'($urandom));
        default: fork
          do_ar(a, 4'($urandom));
          do_write({a[31:6], 4'($urandom_range(0, 15)), 2'b00}, 4'($urandom), $urandom, 4'($urandom));
        join
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 0;
    idle(1);
    rready = 1'b1; bready = 1'b1;
    idle(4);

    // reset while both responses are pending
    rready = 1'b0; bready = 1'b0;
    fork
      do_ar(32'h4, 4'hD);
      do_write(32'h8, 4'hE, 32'h12345678, 4'hF);
    join
    check("pre_reset_pending", {rvalid, bvalid}, 2'b11);
    #2 aresetn = 1'b0;
    #1 check_reset_values("midreset");
    exp_r_q.delete();
    exp_b_q.delete();
    rready = 1'b1; bready = 1'b1;
    @(posedge aclk);
    #3 aresetn = 1'b1;
    idle(1);
    do_ar(32'h8, 4'h1);

    for (int n = 0; n < 100 && (exp_r_q.size() > 0 || exp_b_q.size() > 0); n++) idle(1);
    check("drain", exp_r_q.size() + exp_b_q.size(), 0);
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
